// File: rtl/tb_wait_event_mon.sv
// Wait-event monitor: accepts one WAIT command, watches one bit of i_wait for the
// requested edge/level, and reports done, timeout or abort with the elapsed cycle count.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a command; reject out-of-range alias with o_err
// ST_WAIT | watching r_sel on the sampled bus, counting cycles
module tb_wait_event_mon #(
    parameter int WAIT_ALIAS_NB = 5,
    parameter int SEL_W         = 3,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [SEL_W-1:0]         i_cmd_sel,
    input  logic [1:0]               i_cmd_edge,
    input  logic [CNT_W-1:0]         i_cmd_timeout,
    input  logic                     i_abort,
    input  logic [WAIT_ALIAS_NB-1:0] i_wait,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_timeout,
    output logic                     o_err,
    output logic [CNT_W-1:0]         o_cycles
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0]       EDGE_RISE  = 2'b00;
    localparam logic [1:0]       EDGE_FALL  = 2'b01;
    localparam logic [1:0]       EDGE_ANY   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [WAIT_ALIAS_NB-1:0] r_q;
    logic [WAIT_ALIAS_NB-1:0] r_q2;
    logic [SEL_W-1:0]         r_sel;
    logic [1:0]               r_edge;
    logic [CNT_W-1:0]         r_timeout;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_cycles;
    logic                     r_done;
    logic                     r_tmo;
    logic                     r_err;

    logic                     w_sel_ok;
    logic                     w_cur;
    logic                     w_prev;
    logic                     w_event;
    logic                     w_accept;
    logic                     w_reject;
    logic                     w_abort;
    logic                     w_hit;
    logic                     w_expire;
    logic                     w_step;
    logic [CNT_W-1:0]         w_cnt_inc;

    assign w_sel_ok  = (32'(i_cmd_sel) < 32'(WAIT_ALIAS_NB));
    assign w_cur     = r_q[r_sel];
    assign w_prev    = r_q2[r_sel];
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

    always_comb begin
        w_event = 1'b0;
        case (r_edge)
            EDGE_RISE: w_event = ~w_prev &  w_cur;
            EDGE_FALL: w_event =  w_prev & ~w_cur;
            EDGE_ANY:  w_event =  w_prev ^  w_cur;
            default:   w_event =  w_cur;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort beats event, event beats timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_abort     = 1'b0;
        w_hit       = 1'b0;
        w_expire    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (w_sel_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_event) begin
                    w_hit       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if ((r_timeout != '0) && (r_cnt == (r_timeout - CNT_ONE))) begin
                    w_expire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_step      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // i_wait goes through only two flops so done lands two edges after the input edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_q2      <= '0;
            r_sel     <= '0;
            r_edge    <= '0;
            r_timeout <= '0;
            r_cnt     <= '0;
            r_cycles  <= '0;
            r_done    <= 1'b0;
            r_tmo     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_q    <= i_wait;
            r_q2   <= r_q;
            r_done <= w_hit;
            r_tmo  <= w_expire;
            r_err  <= w_reject;
            if (w_accept) begin
                r_sel     <= i_cmd_sel;
                r_edge    <= i_cmd_edge;
                r_timeout <= i_cmd_timeout;
                r_cnt     <= '0;
            end
            if (w_abort) begin
                r_cycles <= r_cnt;
            end
            if (w_hit) begin
                r_cycles <= w_cnt_inc;
            end
            if (w_expire) begin
                r_cycles <= r_timeout;
            end
            if (w_step) begin
                r_cnt    <= w_cnt_inc;
                r_cycles <= w_cnt_inc;
            end
        end
    end

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state == ST_WAIT);
    assign o_done      = r_done;
    assign o_timeout   = r_tmo;
    assign o_err       = r_err;
    assign o_cycles    = r_cycles;

endmodule

// File: tb/tb_tb_wait_event_mon.sv
// Bench for tb_wait_event_mon: expected results are queued when a command is issued
// and matched against result pulses captured by a negedge monitor.
module tb_tb_wait_event_mon;

    localparam int NB = 5;
    localparam int SW = 3;
    localparam int CW = 32;

    localparam int K_DONE = 0;
    localparam int K_TMO  = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] cycles;
        int          at;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [SW-1:0] i_cmd_sel;
    logic [1:0]    i_cmd_edge;
    logic [CW-1:0] i_cmd_timeout;
    logic          i_abort;
    logic [NB-1:0] i_wait;
    logic          o_busy;
    logic          o_done;
    logic          o_timeout;
    logic          o_err;
    logic [CW-1:0] o_cycles;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic [31:0] last_cycles = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];
    ev_t         mon_ev;

    tb_wait_event_mon #(.WAIT_ALIAS_NB(NB), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_sel    (i_cmd_sel),
        .i_cmd_edge   (i_cmd_edge),
        .i_cmd_timeout(i_cmd_timeout),
        .i_abort      (i_abort),
        .i_wait       (i_wait),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_err        (o_err),
        .o_cycles     (o_cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_done) begin
                mon_ev.kind = K_DONE; mon_ev.cycles = o_cycles; mon_ev.at = cyc;
                obs_q.push_back(mon_ev);
            end
            if (o_timeout) begin
                mon_ev.kind = K_TMO; mon_ev.cycles = o_cycles; mon_ev.at = cyc;
                obs_q.push_back(mon_ev);
            end
            if (o_err) begin
                mon_ev.kind = K_ERR; mon_ev.cycles = o_cycles; mon_ev.at = cyc;
                obs_q.push_back(mon_ev);
            end
        end
    end

    function automatic ev_t mk(input int k, input logic [31:0] c, input int a);
        ev_t e;
        e.kind = k; e.cycles = c; e.at = a;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int sel, input logic [1:0] ed, input logic [31:0] to, output int acc);
        i_cmd_sel     = SW'(sel);
        i_cmd_edge    = ed;
        i_cmd_timeout = to;
        i_cmd_valid   = 1'b1;
        @(posedge clk);
        #1;
        i_cmd_valid   = 1'b0;
        acc           = cyc;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        int k = 0;
        while (obs_q.size() < n && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        int acc;
        rst = 1'b1;
        #12;
        checks++;
        if ({o_busy, o_done, o_timeout, o_err} !== 4'b0000 || o_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: busy/done/tmo/err=%b cycles=%0d, required 0000 and 0",
                     {o_busy, o_done, o_timeout, o_err}, o_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1);
        checks++;
        if ({o_cmd_ready, o_busy, o_done, o_timeout, o_err} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_release: ready/busy/done/tmo/err=%b, required 10000",
                     {o_cmd_ready, o_busy, o_done, o_timeout, o_err});
        end
        send(2, 2'b00, 32'd100, acc);
        step(5);
        checks++;
        if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_before: busy=%b ready=%b, required 1 0", o_busy, o_cmd_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_async: busy=%b ready=%b, required 0 1", o_busy, o_cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        step(3);
        checks++;
        if ({o_cmd_ready, o_busy, o_done, o_timeout, o_err} !== 5'b10000 || o_cycles !== 32'd0) begin
            fails++;
            $display("FAIL reset_midwait: ready/busy/done/tmo/err=%b cycles=%0d, required 10000 and 0",
                     {o_cmd_ready, o_busy, o_done, o_timeout, o_err}, o_cycles);
        end
        checks++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_no_pulse: %0d result pulses seen, required 0", obs_q.size());
        end
        last_cycles = 0;
    endtask

    task automatic test_rise();
        int  acc;
        bit  ok;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        send(2, 2'b00, 32'd100, acc);
        step(4);
        // A command presented while busy must be dropped, not flagged or queued.
        i_cmd_sel = 3'd7; i_cmd_valid = 1'b1;
        step(1);
        i_cmd_valid = 1'b0;
        step(15);
        checks++;
        if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0 || o_cycles !== 32'd20) begin
            fails++;
            $display("FAIL rise_tracking: busy=%b ready=%b cycles=%0d, required 1 0 20",
                     o_busy, o_cmd_ready, o_cycles);
        end
        i_wait[2] = 1'b1;
        exp_q.push_back(mk(K_DONE, 32'd22, acc + 22));
        last_cycles = 22;
        wait_obs(1, ok);
        step(3);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL rise_result: no pulse within bound, required done at cycle %0d", acc + 22);
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cycles !== e.cycles || o.at !== e.at) begin
                fails++;
                $display("FAIL rise_result: kind=%0d cycles=%0d at=%0d, required kind=%0d cycles=%0d at=%0d",
                         o.kind, o.cycles, o.at, e.kind, e.cycles, e.at);
            end
        end
        checks++;
        if (obs_q.size() != 0 || o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL rise_extra: %0d extra pulses ready=%b, required 0 and 1", obs_q.size(), o_cmd_ready);
        end
        i_wait[2] = 1'b0;
        step(3);
    endtask

    task automatic test_timeout();
        int  acc;
        bit  ok;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        send(1, 2'b01, 32'd10, acc);
        exp_q.push_back(mk(K_TMO, 32'd10, acc + 10));
        last_cycles = 10;
        wait_obs(1, ok);
        step(3);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_result: no pulse within bound, required timeout at cycle %0d", acc + 10);
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cycles !== e.cycles || o.at !== e.at) begin
                fails++;
                $display("FAIL timeout_result: kind=%0d cycles=%0d at=%0d, required kind=%0d cycles=%0d at=%0d",
                         o.kind, o.cycles, o.at, e.kind, e.cycles, e.at);
            end
        end
        checks++;
        if (obs_q.size() != 0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL timeout_extra: %0d extra pulses busy=%b, required 0 and 0", obs_q.size(), o_busy);
        end
    endtask

    task automatic test_level();
        int  acc;
        bit  ok;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        i_wait[4] = 1'b1;
        step(3);
        send(4, 2'b11, 32'd0, acc);
        exp_q.push_back(mk(K_DONE, 32'd1, acc + 1));
        last_cycles = 1;
        wait_obs(1, ok);
        step(2);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL level_result: no pulse within bound, required done at cycle %0d", acc + 1);
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cycles !== e.cycles || o.at !== e.at) begin
                fails++;
                $display("FAIL level_result: kind=%0d cycles=%0d at=%0d, required kind=%0d cycles=%0d at=%0d",
                         o.kind, o.cycles, o.at, e.kind, e.cycles, e.at);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL level_extra: %0d extra pulses, required 0", obs_q.size());
        end
        i_wait[4] = 1'b0;
        step(3);
    endtask

    task automatic test_edges();
        int  acc;
        bit  ok;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        i_wait[3] = 1'b1; i_wait[1] = 1'b1; i_wait[0] = 1'b1;
        step(3);
        send(3, 2'b10, 32'd0, acc);
        step(4);
        i_wait[3] = 1'b0;
        exp_q.push_back(mk(K_DONE, 32'd6, acc + 6));
        wait_obs(1, ok);
        send(1, 2'b01, 32'd50, acc);
        step(7);
        i_wait[1] = 1'b0;
        exp_q.push_back(mk(K_DONE, 32'd9, acc + 9));
        wait_obs(2, ok);
        // Falling edge on a rise command must be ignored; the later rise completes it.
        send(0, 2'b00, 32'd30, acc);
        step(2);
        i_wait[0] = 1'b0;
        step(3);
        i_wait[0] = 1'b1;
        exp_q.push_back(mk(K_DONE, 32'd7, acc + 7));
        last_cycles = 7;
        wait_obs(3, ok);
        step(2);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL edges_result%0d: no pulse within bound, required done", i);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cycles !== e.cycles || o.at !== e.at) begin
                    fails++;
                    $display("FAIL edges_result%0d: kind=%0d cycles=%0d at=%0d, required kind=%0d cycles=%0d at=%0d",
                             i, o.kind, o.cycles, o.at, e.kind, e.cycles, e.at);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL edges_extra: %0d extra pulses, required 0", obs_q.size());
        end
        i_wait[0] = 1'b0;
        step(3);
    endtask

    task automatic test_err_abort();
        int  acc;
        bit  ok;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        send(7, 2'b00, 32'd5, acc);
        exp_q.push_back(mk(K_ERR, last_cycles, acc));
        checks++;
        if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL err_state: busy=%b ready=%b, required 0 1", o_busy, o_cmd_ready);
        end
        wait_obs(1, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL err_result: no pulse within bound, required err at cycle %0d", acc);
        end else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.kind !== e.kind || o.cycles !== e.cycles || o.at !== e.at) begin
                fails++;
                $display("FAIL err_result: kind=%0d cycles=%0d at=%0d, required kind=%0d cycles=%0d at=%0d",
                         o.kind, o.cycles, o.at, e.kind, e.cycles, e.at);
            end
        end
        send(0, 2'b10, 32'd0, acc);
        step(49);
        i_abort = 1'b1;
        step(1);
        i_abort = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1 || o_cycles !== 32'd49) begin
            fails++;
            $display("FAIL abort_state: busy=%b ready=%b cycles=%0d, required 0 1 49",
                     o_busy, o_cmd_ready, o_cycles);
        end
        last_cycles = 49;
        step(3);
        checks++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL abort_no_pulse: %0d pulses seen, required 0", obs_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int  acc;
        int  acc2;
        bit  ok;
        ev_t e, o;
        exp_q.delete(); obs_q.delete();
        i_wait[3] = 1'b0; i_wait[4] = 1'b1;
        step(3);
        send(3, 2'b00, 32'd10, acc);
        step(8);
        i_wait[3] = 1'b1;
        exp_q.push_back(mk(K_DONE, 32'd10, acc + 10));
        step(2);
        checks++;
        if (o_done !== 1'b1 || o_timeout !== 1'b0 || o_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done_cycle: done=%b tmo=%b ready=%b, required 1 0 1",
                     o_done, o_timeout, o_cmd_ready);
        end
        send(4, 2'b11, 32'd0, acc2);
        exp_q.push_back(mk(K_DONE, 32'd1, acc2 + 1));
        checks++;
        if (acc2 !== acc + 11 || o_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_accept: accepted at %0d busy=%b, required %0d and 1", acc2, o_busy, acc + 11);
        end
        wait_obs(2, ok);
        step(2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL b2b_result%0d: no pulse within bound, required done", i);
            end else begin
                e = exp_q.pop_front(); o = obs_q.pop_front();
                if (o.kind !== e.kind || o.cycles !== e.cycles || o.at !== e.at) begin
                    fails++;
                    $display("FAIL b2b_result%0d: kind=%0d cycles=%0d at=%0d, required kind=%0d cycles=%0d at=%0d",
                             i, o.kind, o.cycles, o.at, e.kind, e.cycles, e.at);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_extra: %0d extra pulses, required 0", obs_q.size());
        end
    endtask

    initial begin
        i_cmd_valid   = 1'b0;
        i_cmd_sel     = '0;
        i_cmd_edge    = '0;
        i_cmd_timeout = '0;
        i_abort       = 1'b0;
        i_wait        = '0;
        test_reset();
        test_rise();
        test_timeout();
        test_level();
        test_edges();
        test_err_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
